// File: rtl/wptr_full_ctrl_if.sv
// wptr_full_ctrl_if: write-side FIFO pointer, flag and RAM-strobe bundle
interface wptr_full_ctrl_if #(
    parameter int AW = 10
);
    logic          wrt_enable;
    logic [AW:0]   rptr_gray_async;
    logic          ovf_clr;
    logic          wrt_en;
    logic [AW-1:0] waddr;
    logic [AW:0]   wptr;
    logic [AW:0]   wptr_gray;
    logic [AW:0]   wlevel;
    logic          full;
    logic          almost_full;
    logic          overflow;
    modport master (
        output wrt_enable, rptr_gray_async, ovf_clr,
        input  wrt_en, waddr, wptr, wptr_gray, wlevel, full, almost_full, overflow
    );
    modport slave (
        input  wrt_enable, rptr_gray_async, ovf_clr,
        output wrt_en, waddr, wptr, wptr_gray, wlevel, full, almost_full, overflow
    );
endinterface

// File: rtl/wptr_full_ctrl.sv
// wptr_full_ctrl: async-FIFO write pointer, full/almost-full and overflow control
module wptr_full_ctrl #(
    parameter int depth       = 1024,
    parameter int SYNC_STAGES = 2,
    parameter int AF_THRESH   = depth - 2
) (
    input  logic           clk_w,
    input  logic           rst_w,
    wptr_full_ctrl_if.slave bus
);
    localparam int          AW      = $clog2(depth);
    localparam logic [AW:0] DEPTH_V = (AW+1)'(depth);
    localparam logic [AW:0] AF_V    = (AW+1)'(AF_THRESH);

    logic [AW:0] sync_q [SYNC_STAGES];
    logic [AW:0] rgray_s;
    logic [AW:0] rbin_s;
    logic [AW:0] wptr_q, wptr_d;
    logic [AW:0] wgray_q, wgray_d;
    logic [AW:0] wlevel_q, wlevel_d;
    logic        full_q, full_d;
    logic        af_q, af_d;
    logic        ovf_q, ovf_d;
    logic        en_w;

    assign rgray_s = sync_q[SYNC_STAGES-1];

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it
    always_comb begin
        rbin_s = '0;
        for (int i = 0; i <= AW; i++) rbin_s[i] = ^(rgray_s >> i);
    end

    assign en_w     = bus.wrt_enable & ~full_q & ~rst_w;
    assign wptr_d   = wptr_q + (AW+1)'(en_w);
    assign wgray_d  = wptr_d ^ (wptr_d >> 1);
    assign wlevel_d = wptr_d - rbin_s;
    assign full_d   = wlevel_d == DEPTH_V;
    assign af_d     = wlevel_d >= AF_V;
    assign ovf_d    = (bus.wrt_enable & full_q) | (ovf_q & ~bus.ovf_clr);

    // Read-pointer synchronizer chain into the write clock domain
    always_ff @(posedge clk_w) begin
        if (rst_w) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= bus.rptr_gray_async;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    // Write pointer, its Gray image, level and flags all advance on the same edge
    always_ff @(posedge clk_w) begin
        if (rst_w) begin
            wptr_q   <= '0;
            wgray_q  <= '0;
            wlevel_q <= '0;
            full_q   <= 1'b0;
            af_q     <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            wgray_q  <= wgray_d;
            wlevel_q <= wlevel_d;
            full_q   <= full_d;
            af_q     <= af_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.wrt_en      = en_w;
    assign bus.waddr       = wptr_q[AW-1:0];
    assign bus.wptr        = wptr_q;
    assign bus.wptr_gray   = wgray_q;
    assign bus.wlevel      = wlevel_q;
    assign bus.full        = full_q;
    assign bus.almost_full = af_q;
    assign bus.overflow    = ovf_q;
endmodule

// File: doc/wptr_full_ctrl.md
WPTR_FULL_CTRL -- requirements
Module: wptr_full_ctrl

Interface
REQ-001 SHALL have parameter depth, default 1024, meaning FIFO entries, a power of two >= 2; AW = $clog2(depth).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning read-pointer synchronizer flops, legal range 2..4.
REQ-003 SHALL have parameter AF_THRESH, default depth-2, meaning almost-full level threshold, legal range 1..depth.
REQ-004 clk_w  in  1  write-domain clock; sole clock of the block.
REQ-005 rst_w  in  1  reset, synchronous and active-high, sampled on the rising edge of clk_w.
REQ-006 wrt_enable  in  1  write request from the producer.
REQ-007 rptr_gray_async  in  AW+1  Gray-coded read pointer from the read domain, asynchronous to clk_w.
REQ-008 ovf_clr  in  1  clears the sticky overflow flag.
REQ-009 wrt_en  out  1  qualified write strobe to RAM, equal to wrt_enable & ~full.
REQ-010 waddr  out  AW  RAM write address, equal to wptr[AW-1:0].
REQ-011 wptr  out  AW+1  binary write pointer, registered, with the MSB as the wrap bit.
REQ-012 wptr_gray  out  AW+1  Gray code of wptr, registered, for export to the read domain.
REQ-013 full  out  1  registered full flag.
REQ-014 almost_full  out  1  registered, asserted when wlevel >= AF_THRESH.
REQ-015 wlevel  out  AW+1  registered fill level as seen from the write domain, range 0..depth.
REQ-016 overflow  out  1  sticky flag, set on a write attempted while full.

Function
REQ-017 rptr_gray_async SHALL pass through a SYNC_STAGES-deep flop chain; the last stage is rgray_s.
REQ-018 rgray_s SHALL be converted combinationally from Gray to binary, giving rbin_s of AW+1 bits.
REQ-019 On each edge with wrt_en=1, wptr SHALL increment by 1 modulo 2^(AW+1); otherwise it SHALL hold.
REQ-020 wptr_gray SHALL be loaded on the same edge as wptr with next_wptr ^ (next_wptr >> 1); the two outputs SHALL never disagree.
REQ-021 wlevel SHALL be registered as (next_wptr - rbin_s) mod 2^(AW+1).
REQ-022 full SHALL be registered as (next wlevel == depth); almost_full SHALL be registered as (next wlevel >= AF_THRESH).
REQ-023 Write-side latency SHALL be 0 cycles: an accepted write updates wptr, wptr_gray, wlevel, full and almost_full at that same edge, so a back-to-back write on the next cycle sees the updated full.
REQ-024 Read-side latency SHALL be SYNC_STAGES+1 edges from a change of rptr_gray_async to the corresponding update of wlevel, full and almost_full; full is therefore pessimistic and SHALL never be deasserted early.
REQ-025 When wrt_enable=1 and full=1, wrt_en SHALL be 0, wptr SHALL hold, and overflow SHALL be set at the next edge.
REQ-026 ovf_clr SHALL clear overflow at the next edge; if set and clear coincide, set SHALL win.
REQ-027 Pointer wrap from 2^(AW+1)-1 to 0 SHALL be seamless: level arithmetic stays correct and the Gray code changes by exactly one bit.
REQ-028 For depth=2 (AW=1), all width rules SHALL hold with no zero-width slices.

Reset
REQ-029 With rst_w=1 at an edge: wptr, wptr_gray, wlevel, the synchronizer chain and overflow SHALL be 0; full=0; almost_full=0.
REQ-030 Reset SHALL override wrt_enable and ovf_clr on the same edge. wrt_en SHALL be 0 while rst_w=1.
REQ-031 Reset asserted mid-operation SHALL discard the pending write.

Verification (depth=8, SYNC_STAGES=2, AF_THRESH=6)
REQ-032 Reset, then 8 writes with rptr_gray_async=0 -> full=1 after the 8th edge; wptr=8, wptr_gray=4'b1100, wlevel=8.
REQ-033 During that fill -> almost_full=1 from the edge where wlevel becomes 6, and 0 before it.
REQ-034 While full, a 9th write -> wrt_en=0, wptr stays 8, overflow=1 next edge; then ovf_clr=1 together with wrt_enable=1 -> overflow stays 1; ovf_clr=1 alone -> overflow=0.
REQ-035 While full, set rptr_gray_async=4'b0010 (binary 3) -> full and almost_full drop exactly 3 edges later, with wlevel=5.
REQ-036 Stream of 20 writes with the reader tracking -> wptr wraps 15->0, wptr_gray 4'b1000->4'b0000, wlevel never exceeds 8.
REQ-037 rst_w=1 for one edge mid-stream with wrt_enable=1 -> all outputs 0 after that edge, and the next write lands at waddr=0.
